seq_game_ctrl: RTL
==================

# seq_game_ctrl

Sequencing controller for the 4-step-wide LED memory game. It drives the address of the one-hot sequence ROM, plays back the first N sequence steps on the LEDs, then checks the player's button presses against the same ROM entries. Each cleared round grows N by one, up to 16; N = 16 cleared is a win, a wrong press (or timeout) is a fail. Sits between the button debouncers and the sequence ROM / LED drivers.

## Interface
- ON_CYCLES, 4, clock cycles a step is lit during playback (≥1)
- OFF_CYCLES, 2, dark cycles after each lit step and before each replay (≥1)
- TIMEOUT_CYCLES, 64, max idle cycles while waiting for a press (used only with INPUT_TIMEOUT_EN)
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a game from IDLE, WIN or FAIL
- btn  input  4  debounced one-cycle press pulses, bit i = button i
- rom_data  input  4  combinational one-hot ROM output for rom_addr
- rom_addr  output  4  registered step index presented to ROM
- leds  output  4  LED drive
- level  output  5  current round length N (0 in IDLE, 1..16)
- busy  output  1  high in any state except IDLE/WIN/FAIL
- win  output  1  high while in WIN
- fail  output  1  high while in FAIL

## Operation
- States: IDLE, SHOW_ON, SHOW_OFF, INPUT, WIN, FAIL. Internal: step[3:0], timer.
- Reset: state=IDLE, rom_addr=0, step=0, level=0, timer=0; leds=0, busy=0, win=0, fail=0.
- IDLE/WIN/FAIL: start=1 → level=1, step=0, timer=0, next SHOW_ON. start ignored in all other states. btn ignored in these states.
- rom_addr always equals step (registered together).
- SHOW_ON: leds=rom_data. After ON_CYCLES cycles → SHOW_OFF, timer=0.
- SHOW_OFF: leds=0. After OFF_CYCLES cycles: if step==level-1 → step=0, INPUT; else step+1, SHOW_ON.
- INPUT: leds=btn (echo, same cycle). Any cycle with btn≠0 is a press:
  - btn==rom_data exactly (multi-bit press never matches) and step<level-1 → step+1, stay INPUT.
  - match and step==level-1 and level<16 → level+1, step=0, SHOW_OFF (a dark gap of OFF_CYCLES precedes the replay; that SHOW_OFF then goes to SHOW_ON since step≠level-1).
  - match and step==level-1 and level==16 → WIN.
  - mismatch → FAIL.
- WIN/FAIL: leds=4'b1111 (WIN) / 4'b0000 (FAIL); level holds its last value.
- level saturates at 16; step never exceeds level-1.
- Playback gap rule: SHOW_OFF entered from INPUT with step=0 always returns to SHOW_ON.

## Timing
- Outputs state, rom_addr, level, busy, win and fail are registered. leds is combinational from registered state, rom_data and btn.
- start sampled at edge k → busy=1, level=1, SHOW_ON with rom_addr=0 from cycle k+1; leds lit cycles k+1..k+ON_CYCLES.
- One full playback step = ON_CYCLES+OFF_CYCLES cycles. Round N playback = N·(ON_CYCLES+OFF_CYCLES).
- A press is evaluated at the edge it is sampled. The resulting state, step and level are visible the next cycle. Back-to-back presses on consecutive cycles are each evaluated.
- Asynchronous reset mid-game returns immediately to IDLE values. No pending press or timer survives.

## Configuration
- INPUT_TIMEOUT_EN defined: in INPUT, timer counts cycles without a press and clears on every correct press. Reaching TIMEOUT_CYCLES with no press → FAIL on that edge.
- Undefined: no timeout logic. INPUT waits indefinitely. TIMEOUT_CYCLES is unused.

## Test plan
- Reset, start, press 4'b0001 during INPUT of round 1 → level=2; replay shows 0001 then 1000 on leds, each lit 4 cycles (ON_CYCLES=4).
- Round 2, press 0001 then 0100 (expected 1000) → fail=1, busy=0, leds=0000, level=2.
- Press 4'b1001 when 4'b0001 is expected → FAIL (multi-bit press is a mismatch).
- Play all 16 rounds correctly from ROM contents → win=1, leds=1111, level=16. Then start → level=1, SHOW_ON.
- INPUT_TIMEOUT_EN, TIMEOUT_CYCLES=64, no press for 64 cycles in INPUT → fail=1. Without the macro, idle 1000 cycles → still INPUT, busy=1.
- Assert rst_n=0 during SHOW_ON of round 3 → same cycle: leds=0, level=0, busy=0, rom_addr=0. start ignored while busy (pulse mid-playback leaves level/step unchanged).

Source files
------------

// File: rtl/seq_game_ctrl_if.sv
// Signal bundle between the LED memory-game sequencer and its surroundings:
// start pulse and debounced buttons in, sequence ROM address/data, LED drive
// and game status out. The controller uses the slave side; whatever drives
// start/btn and supplies ROM data uses the master side.
interface seq_game_ctrl_if;
  logic       start;
  logic [3:0] btn;
  logic [3:0] rom_data;
  logic [3:0] rom_addr;
  logic [3:0] leds;
  logic [4:0] level;
  logic       busy;
  logic       win;
  logic       fail;

  modport master (
    output start, btn, rom_data,
    input  rom_addr, leds, level, busy, win, fail
  );

  modport slave (
    input  start, btn, rom_data,
    output rom_addr, leds, level, busy, win, fail
  );
endinterface

// File: rtl/seq_game_ctrl.sv
// Sequencing controller for the 4-button LED memory game.
// Plays back the first N one-hot ROM steps on the LEDs, then checks the
// player's presses against the same entries; each cleared round grows N up
// to 16, clearing round 16 wins, a wrong press fails.
// Optional feature: define INPUT_TIMEOUT_EN to fail the game after
// TIMEOUT_CYCLES consecutive cycles without a press while waiting for input.
module seq_game_ctrl #(
  parameter int ON_CYCLES      = 4,
  parameter int OFF_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_game_ctrl_if.slave       bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_INPUT,
    S_WIN,
    S_FAIL
  } state_t;

  // One shared timer covers lit, dark and idle-wait intervals.
  localparam int MAX_ON_OFF = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_CYC    = (MAX_ON_OFF > TIMEOUT_CYCLES) ? MAX_ON_OFF : TIMEOUT_CYCLES;
  localparam int TW         = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);
`ifdef INPUT_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
`endif

  localparam logic [4:0] LEVEL_MAX = 5'd16;

  state_t        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [4:0]    level_q, level_d;
  logic [TW-1:0] timer_q, timer_d;
  // Set when SHOW_OFF is the dark gap before a replay: it must return to
  // SHOW_ON with step still 0 instead of advancing the step.
  logic          gap_q, gap_d;
  logic          busy_q, busy_d;
  logic          win_q, win_d;
  logic          fail_q, fail_d;

  logic          last_step;
  logic          press;
  logic          match;
  logic [3:0]    leds_c;

  assign last_step = ({1'b0, step_q} == (level_q - 5'd1));
  assign press     = |bus.btn;
  assign match     = (bus.btn == bus.rom_data);

  // State register with asynchronous return to idle values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= 4'd0;
      level_q <= 5'd0;
      timer_q <= '0;
      gap_q   <= 1'b0;
      busy_q  <= 1'b0;
      win_q   <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      level_q <= level_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
      fail_q  <= fail_d;
    end
  end

  // Next-state logic: playback timing, press evaluation and round growth.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    level_d = level_q;
    timer_d = timer_q;
    gap_d   = gap_q;

    case (state_q)
      S_IDLE, S_WIN, S_FAIL: begin
        if (bus.start) begin
          level_d = 5'd1;
          step_d  = 4'd0;
          timer_d = '0;
          gap_d   = 1'b0;
          state_d = S_SHOW_ON;
        end
      end

      S_SHOW_ON: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = S_SHOW_OFF;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_SHOW_OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (gap_q) begin
            gap_d   = 1'b0;
            state_d = S_SHOW_ON;
          end else if (last_step) begin
            step_d  = 4'd0;
            state_d = S_INPUT;
          end else begin
            step_d  = step_q + 4'd1;
            state_d = S_SHOW_ON;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_INPUT: begin
        if (press) begin
          timer_d = '0;
          if (!match) begin
            state_d = S_FAIL;
          end else if (!last_step) begin
            step_d = step_q + 4'd1;
          end else if (level_q < LEVEL_MAX) begin
            level_d = level_q + 5'd1;
            step_d  = 4'd0;
            gap_d   = 1'b1;
            state_d = S_SHOW_OFF;
          end else begin
            state_d = S_WIN;
          end
        end else begin
`ifdef INPUT_TIMEOUT_EN
          if (timer_q == TO_LAST) begin
            timer_d = '0;
            state_d = S_FAIL;
          end else begin
            timer_d = timer_q + TW'(1);
          end
`else
          timer_d = timer_q;
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so they register with it.
  always_comb begin
    busy_d = (state_d == S_SHOW_ON) || (state_d == S_SHOW_OFF) || (state_d == S_INPUT);
    win_d  = (state_d == S_WIN);
    fail_d = (state_d == S_FAIL);
  end

  // LED drive: ROM step while lit, button echo while waiting, all on for a win.
  always_comb begin
    leds_c = 4'b0000;
    case (state_q)
      S_SHOW_ON: leds_c = bus.rom_data;
      S_INPUT:   leds_c = bus.btn;
      S_WIN:     leds_c = 4'b1111;
      default:   leds_c = 4'b0000;
    endcase
  end

  assign bus.rom_addr = step_q;
  assign bus.leds     = leds_c;
  assign bus.level    = level_q;
  assign bus.busy     = busy_q;
  assign bus.win      = win_q;
  assign bus.fail     = fail_q;

endmodule
